// File: rtl/int_ctrl.sv
// Multi-source, fixed-priority interrupt controller with MMIO register file.
// Optional macro INT_EDGE_DETECT_EN selects rising-edge sources; default is level-sensitive.
//
// state       | meaning
// ST_IDLE     | waiting; accepts interrupts when GIE is set
// ST_DISPATCH | one-cycle int_req pulse to the cpu
// ST_SERVICE  | handler running; left only by an IRET write
module int_ctrl #(
  parameter int         N_SRC      = 4,
  parameter logic [7:0] BASE_ADDR  = 8'd240,
  parameter int         VEC_STRIDE = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic [7:0]       addr,
  input  logic [7:0]       w_data,
  input  logic             w_en,
  input  logic [7:0]       ret_addr,
  output logic [7:0]       r_data,
  output logic             r_hit,
  output logic             int_req,
  output logic [7:0]       int_en,
  output logic [7:0]       int_vec
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_SERVICE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       vec_base;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] pending;
  logic [7:0]       ret_q;
  logic [2:0]       id_q;
  logic             gie;
  logic [7:0]       int_vec_q;

  logic [7:0]       off;
  logic             wr_vec, wr_mask, wr_pend, wr_ctrl, iret;
  logic [N_SRC-1:0] req, src_evt, w1c_bits, sel_oh;
  logic [2:0]       sel;
  logic             dispatch;
  logic             in_service;
  logic [7:0]       vec_off;

  // Unsigned wrap makes addresses below BASE_ADDR fall outside the window.
  assign off   = addr - BASE_ADDR;
  assign r_hit = (off < 8'd6);

  assign wr_vec  = w_en && r_hit && (off == 8'd0);
  assign wr_mask = w_en && r_hit && (off == 8'd1);
  assign wr_pend = w_en && r_hit && (off == 8'd2);
  assign wr_ctrl = w_en && r_hit && (off == 8'd5);
  assign iret    = wr_ctrl && w_data[1] && (state == ST_SERVICE);

  assign in_service = (state == ST_SERVICE);
  assign req        = pending & mask;

`ifdef INT_EDGE_DETECT_EN
  logic [N_SRC-1:0] src_q;

  always_ff @(posedge clock) begin
    if (reset) src_q <= '0;
    else       src_q <= src;
  end

  assign src_evt = src & ~src_q;
`else
  assign src_evt = src;
`endif

  always_comb begin
    sel = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) sel = 3'(i);
    end
  end

  assign vec_off  = 8'(32'(sel) * VEC_STRIDE);
  assign w1c_bits = wr_pend ? w_data[N_SRC-1:0] : '0;
  assign sel_oh   = dispatch ? (N_SRC'(1) << sel) : '0;

  always_comb begin
    state_nxt = state;
    int_req   = 1'b0;
    int_en    = 8'h00;
    dispatch  = 1'b0;
    case (state)
      ST_IDLE: begin
        int_en = gie ? 8'h01 : 8'h00;
        if (gie && (|req)) begin
          state_nxt = ST_DISPATCH;
          dispatch  = 1'b1;
        end
      end
      ST_DISPATCH: begin
        int_req   = 1'b1;
        state_nxt = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (iret) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Capture happens on the IDLE->DISPATCH edge so vector and return address
  // are already valid while int_req is high. A same-cycle set beats any clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      vec_base  <= 8'h00;
      mask      <= '0;
      pending   <= '0;
      ret_q     <= 8'h00;
      id_q      <= 3'd0;
      gie       <= 1'b0;
      int_vec_q <= 8'h00;
    end else begin
      state   <= state_nxt;
      pending <= (pending & ~(w1c_bits | sel_oh)) | src_evt;
      if (wr_vec)  vec_base <= w_data;
      if (wr_mask) mask     <= w_data[N_SRC-1:0];
      if (wr_ctrl) gie      <= w_data[0];
      if (dispatch) begin
        ret_q     <= ret_addr;
        id_q      <= sel;
        int_vec_q <= vec_base + vec_off;
      end
    end
  end

  assign int_vec = int_vec_q;

  always_comb begin
    r_data = 8'h00;
    if (r_hit) begin
      case (off)
        8'd0:    r_data = vec_base;
        8'd1:    r_data = 8'(mask);
        8'd2:    r_data = 8'(pending);
        8'd3:    r_data = ret_q;
        8'd4:    r_data = {in_service, 4'b0000, id_q};
        default: r_data = 8'h00;
      endcase
    end
  end

endmodule
